// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and sizes for the pipeline hazard controller.
//   state_e : controller FSM states (RUN, BR_FLUSH, MEM_WAIT)
//   REG_W   : register specifier width
//   CNT_W   : performance counter width
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low (clears count)
//   inc   : count this cycle
//   count : current count value
module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = hazard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/flush/freeze controller for a 5-stage pipeline.
// Handles load-use bubbles, the 2-cycle taken-branch flush and data-memory
// wait freezes. A branch flush interrupted by a memory wait is remembered
// in a pending bit and replayed once memory is ready.
// Ports:
//   clk, rst              : clock (rising edge), async reset (active low)
//   id_rs, id_rt          : source registers of the ID instruction
//   id_uses_rt            : ID instruction actually reads rt
//   ex_mem_read, ex_rt    : EX instruction is a load, and its destination
//   ex_branch_taken       : EX branch resolved taken
//   mem_ready             : data memory finished its access
//   Controller_Flush      : zero the ID control word entering ID/EX
//   pc_write, ifid_write  : PC and IF/ID enables
//   ifid_flush            : clear IF/ID to a NOP
//   pipe_freeze           : hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt, wait_cnt : saturating performance counters
// Configuration: define HAZARD_PERF_CNT_EN to build the counters; otherwise
// the counter ports read constant zero and no counter flops exist.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             Controller_Flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   load_use;
  logic   run_rules;

  // r0 is hardwired to zero, so a load into it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    run_rules        = 1'b0;
    Controller_Flush = 1'b0;
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    ifid_flush       = 1'b0;
    pipe_freeze      = 1'b0;

    unique case (state_q)
      RUN: run_rules = 1'b1;

      BR_FLUSH: begin
        if (mem_ready) begin
          Controller_Flush = 1'b1;
          ifid_flush       = 1'b1;
          state_d          = RUN;
        end else begin
          // Memory wait wins; the second flush cycle is owed afterwards.
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pending_d   = 1'b1;
          state_d     = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          run_rules = 1'b1;
        end else begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
        end
      end

      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (!mem_ready) begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        state_d     = MEM_WAIT;
      end else if (ex_branch_taken) begin
        // First flush cycle; PC loads the branch target.
        Controller_Flush = 1'b1;
        ifid_flush       = 1'b1;
        state_d          = BR_FLUSH;
      end else if (load_use) begin
        // One bubble: hold PC and IF/ID, squash the ID control word.
        Controller_Flush = 1'b1;
        pc_write         = 1'b0;
        ifid_write       = 1'b0;
        state_d          = RUN;
      end else begin
        state_d = RUN;
      end

      // Leaving MEM_WAIT with an owed flush replays the BR_FLUSH cycle.
      if ((state_q == MEM_WAIT) && pending_q) begin
        state_d   = BR_FLUSH;
        pending_d = 1'b0;
      end
    end

    // Held in reset the pipeline runs freely with no flush or freeze.
    if (!rst) begin
      Controller_Flush = 1'b0;
      pc_write         = 1'b1;
      ifid_write       = 1'b1;
      ifid_flush       = 1'b0;
      pipe_freeze      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc, wait_inc;

  // A branch flush always clears IF/ID; a load-use bubble never does.
  assign stall_inc = Controller_Flush && !ifid_flush;
  assign flush_inc = Controller_Flush && ifid_flush;
  assign wait_inc  = !mem_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .count (wait_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Counter expectations collapse to zero when HAZARD_PERF_CNT_EN is undefined.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_ready;
  logic        Controller_Flush, pc_write, ifid_write, ifid_flush, pipe_freeze;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;

  int tests = 0;
  int fails = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector {Controller_Flush, pc_write, ifid_write, ifid_flush, pipe_freeze}
  localparam logic [4:0] O_NORM  = 5'b01100;
  localparam logic [4:0] O_BUB   = 5'b10000;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_FRZ   = 5'b00001;

  logic [4:0]  outs;
  logic [15:0] exp_stall, exp_flush, exp_wait;

  assign outs = {Controller_Flush, pc_write, ifid_write, ifid_flush, pipe_freeze};

  hazard_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .ex_branch_taken  (ex_branch_taken),
    .mem_ready        (mem_ready),
    .Controller_Flush (Controller_Flush),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .pipe_freeze      (pipe_freeze),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .wait_cnt         (wait_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ce(input logic [15:0] v);
    return PERF ? v : 16'h0000;
  endfunction

  task automatic idle_inputs();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic load_use_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL reset_outs: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); #1;
    tests++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== 48'h0) begin
      $display("FAIL reset_cnts: got %h/%h/%h expected 0/0/0", stall_cnt, flush_cnt, wait_cnt); fails++;
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    exp_stall = 16'd0; exp_flush = 16'd0; exp_wait = 16'd0;
  endtask

  task automatic test_load_use();
    @(negedge clk); idle_inputs(); load_use_inputs(); #1;
    tests++;
    if (outs !== O_BUB) begin
      $display("FAIL load_use_rs: got %b expected %b", outs, O_BUB); fails++;
    end
    exp_stall++;
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL load_use_after: got %b expected %b", outs, O_NORM); fails++;
    end
    tests++;
    if (stall_cnt !== ce(exp_stall)) begin
      $display("FAIL load_use_cnt1: got %0d expected %0d", stall_cnt, ce(exp_stall)); fails++;
    end
    // Hazard through rt when rt is used.
    @(negedge clk); idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1; #1;
    tests++;
    if (outs !== O_BUB) begin
      $display("FAIL load_use_rt: got %b expected %b", outs, O_BUB); fails++;
    end
    exp_stall++;
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (stall_cnt !== ce(exp_stall)) begin
      $display("FAIL load_use_cnt2: got %0d expected %0d", stall_cnt, ce(exp_stall)); fails++;
    end
  endtask

  task automatic test_no_stall();
    @(negedge clk); idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL no_stall_r0: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 1'b0; #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL no_stall_unused_rt: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); idle_inputs();
    ex_mem_read = 1'b0; ex_rt = 5'd8; id_rs = 5'd8; #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL no_stall_not_load: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (stall_cnt !== ce(exp_stall)) begin
      $display("FAIL no_stall_cnt: got %0d expected %0d", stall_cnt, ce(exp_stall)); fails++;
    end
  endtask

  task automatic test_branch();
    // Load-use presented alongside the branch must be ignored.
    @(negedge clk); idle_inputs(); load_use_inputs(); ex_branch_taken = 1'b1; #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL branch_c1: got %b expected %b", outs, O_FLUSH); fails++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL branch_c2: got %b expected %b", outs, O_FLUSH); fails++;
    end
    exp_flush += 16'd2;
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL branch_back_run: got %b expected %b", outs, O_NORM); fails++;
    end
    tests++;
    if ({flush_cnt, stall_cnt} !== {ce(exp_flush), ce(exp_stall)}) begin
      $display("FAIL branch_cnts: got flush %0d stall %0d expected %0d %0d",
               flush_cnt, stall_cnt, ce(exp_flush), ce(exp_stall)); fails++;
    end
  endtask

  task automatic test_branch_mem_stall();
    @(negedge clk); idle_inputs(); ex_branch_taken = 1'b1; #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL brms_branch: got %b expected %b", outs, O_FLUSH); fails++;
    end
    exp_flush++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs(); mem_ready = 1'b0; #1;
      tests++;
      if (outs !== O_FRZ) begin
        $display("FAIL brms_freeze%0d: got %b expected %b", i, outs, O_FRZ); fails++;
      end
      exp_wait++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL brms_exit: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL brms_replay: got %b expected %b", outs, O_FLUSH); fails++;
    end
    exp_flush++;
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL brms_done: got %b expected %b", outs, O_NORM); fails++;
    end
    tests++;
    if ({wait_cnt, flush_cnt} !== {ce(exp_wait), ce(exp_flush)}) begin
      $display("FAIL brms_cnts: got wait %0d flush %0d expected %0d %0d",
               wait_cnt, flush_cnt, ce(exp_wait), ce(exp_flush)); fails++;
    end
  endtask

  task automatic test_mem_priority();
    // Memory wait beats a branch and a load-use in RUN and in MEM_WAIT.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle_inputs(); load_use_inputs();
      ex_branch_taken = 1'b1; mem_ready = 1'b0; #1;
      tests++;
      if (outs !== O_FRZ) begin
        $display("FAIL prio_freeze%0d: got %b expected %b", i, outs, O_FRZ); fails++;
      end
      exp_wait++;
    end
    @(negedge clk); idle_inputs(); load_use_inputs(); ex_branch_taken = 1'b1; #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL prio_exit_branch: got %b expected %b", outs, O_FLUSH); fails++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_FLUSH) begin
      $display("FAIL prio_br_flush: got %b expected %b", outs, O_FLUSH); fails++;
    end
    exp_flush += 16'd2;
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== {ce(exp_stall), ce(exp_flush), ce(exp_wait)}) begin
      $display("FAIL prio_cnts: got %0d/%0d/%0d expected %0d/%0d/%0d", stall_cnt, flush_cnt,
               wait_cnt, ce(exp_stall), ce(exp_flush), ce(exp_wait)); fails++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle_inputs(); ex_branch_taken = 1'b1;
    @(negedge clk); idle_inputs(); mem_ready = 1'b0;
    @(negedge clk); idle_inputs(); mem_ready = 1'b0; #1;
    tests++;
    if (outs !== O_FRZ) begin
      $display("FAIL areset_pre: got %b expected %b", outs, O_FRZ); fails++;
    end
    #2 rst = 1'b0; #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL areset_outs: got %b expected %b", outs, O_NORM); fails++;
    end
    tests++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== 48'h0) begin
      $display("FAIL areset_cnts: got %h/%h/%h expected 0/0/0", stall_cnt, flush_cnt, wait_cnt); fails++;
    end
    @(negedge clk); idle_inputs(); rst = 1'b1; #1;
    exp_stall = 16'd0; exp_flush = 16'd0; exp_wait = 16'd0;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL areset_rel1: got %b expected %b", outs, O_NORM); fails++;
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (outs !== O_NORM) begin
      $display("FAIL areset_no_pending: got %b expected %b", outs, O_NORM); fails++;
    end
    tests++;
    if ({flush_cnt, wait_cnt} !== 32'h0) begin
      $display("FAIL areset_cnts_after: got flush %0d wait %0d expected 0 0", flush_cnt, wait_cnt); fails++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; idle_inputs(); load_use_inputs();
    repeat (65535) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (stall_cnt !== ce(16'hFFFF)) begin
      $display("FAIL sat_reach: got %h expected %h", stall_cnt, ce(16'hFFFF)); fails++;
    end
    tests++;
    if (outs !== O_BUB) begin
      $display("FAIL sat_outs: got %b expected %b", outs, O_BUB); fails++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (stall_cnt !== ce(16'hFFFF)) begin
      $display("FAIL sat_hold: got %h expected %h", stall_cnt, ce(16'hFFFF)); fails++;
    end
    tests++;
    if ({flush_cnt, wait_cnt} !== 32'h0) begin
      $display("FAIL sat_others: got flush %0d wait %0d expected 0 0", flush_cnt, wait_cnt); fails++;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_branch_mem_stall();
    test_mem_priority();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
